// File: rtl/rv_enc_pkg.sv
// rtl/rv_enc_pkg.sv - format codes, RV32I opcodes and descriptor type for the instruction encoder
package rv_enc_pkg;

  localparam logic [2:0] FMT_R = 3'd0;
  localparam logic [2:0] FMT_I = 3'd1;
  localparam logic [2:0] FMT_S = 3'd2;
  localparam logic [2:0] FMT_B = 3'd3;
  localparam logic [2:0] FMT_U = 3'd4;
  localparam logic [2:0] FMT_J = 3'd5;

  localparam logic [6:0] OPC_OP     = 7'h33;
  localparam logic [6:0] OPC_OP_IMM = 7'h13;
  localparam logic [6:0] OPC_LOAD   = 7'h03;
  localparam logic [6:0] OPC_STORE  = 7'h23;
  localparam logic [6:0] OPC_BRANCH = 7'h63;
  localparam logic [6:0] OPC_JAL    = 7'h6F;
  localparam logic [6:0] OPC_JALR   = 7'h67;
  localparam logic [6:0] OPC_LUI    = 7'h37;
  localparam logic [6:0] OPC_AUIPC  = 7'h17;

  typedef struct packed {
    logic [2:0]  fmt;
    logic [6:0]  opcode;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
  } enc_desc_t;

endpackage

// File: rtl/rv_enc_fifo2.sv
// rtl/rv_enc_fifo2.sv - 2-entry in-order FIFO with synchronous clear
module rv_enc_fifo2 #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             valid,
  output logic             full,
  output logic [WIDTH-1:0] head
);

  logic [WIDTH-1:0] mem0;
  logic [WIDTH-1:0] mem1;
  logic             rd_ptr;
  logic             wr_ptr;
  logic [1:0]       count;

  // Caller guarantees push only when !full and pop only when valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem0   <= '0;
      mem1   <= '0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else if (clear) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        if (wr_ptr) mem1 <= push_data;
        else        mem0 <= push_data;
        wr_ptr <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

  assign valid = (count != 2'd0);
  assign full  = (count == 2'd2);
  assign head  = rd_ptr ? mem1 : mem0;

endmodule

// File: rtl/rv_instr_encoder.sv
// rtl/rv_instr_encoder.sv - streaming RV32I descriptor-to-word encoder with address tagging
// Optional descriptor legality checking enabled by defining ENC_ILLEGAL_CHECK_EN.
module rv_instr_encoder
  import rv_enc_pkg::*;
#(
  parameter int               ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_fmt,
  input  logic [6:0]        in_opcode,
  input  logic [2:0]        in_f3,
  input  logic [6:0]        in_f7,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [31:0]       in_imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_instr,
  output logic [ADDR_W-1:0] out_addr,
  output logic              err
);

  enc_desc_t   desc;
  logic [31:0] word;
  logic        full;
  logic        accept;
  logic        illegal;
  logic        push;
  logic        pop;

  assign desc = '{fmt: in_fmt, opcode: in_opcode, f3: in_f3, f7: in_f7,
                  rd: in_rd, rs1: in_rs1, rs2: in_rs2, imm: in_imm};

  always_comb begin
    word = {desc.f7, desc.rs2, desc.rs1, desc.f3, desc.rd, desc.opcode};
    case (desc.fmt)
      FMT_I: word = {desc.imm[11:0], desc.rs1, desc.f3, desc.rd, desc.opcode};
      FMT_S: word = {desc.imm[11:5], desc.rs2, desc.rs1, desc.f3, desc.imm[4:0], desc.opcode};
      FMT_B: word = {desc.imm[12], desc.imm[10:5], desc.rs2, desc.rs1, desc.f3,
                     desc.imm[4:1], desc.imm[11], desc.opcode};
      FMT_U: word = {desc.imm[31:12], desc.rd, desc.opcode};
      FMT_J: word = {desc.imm[20], desc.imm[10:1], desc.imm[11], desc.imm[19:12],
                     desc.rd, desc.opcode};
      default: ;  // R, and unassigned codes fall back to R packing
    endcase
  end

`ifdef ENC_ILLEGAL_CHECK_EN
  logic signed [31:0] imm_s;
  logic               err_q;

  assign imm_s = $signed(desc.imm);

  always_comb begin
    illegal = 1'b0;
    case (desc.fmt)
      FMT_R:        illegal = 1'b0;
      FMT_I, FMT_S: illegal = (imm_s < -2048) || (imm_s > 2047);
      FMT_B:        illegal = (imm_s < -4096) || (imm_s > 4094) || desc.imm[0];
      FMT_U:        illegal = (desc.imm[11:0] != 12'd0);
      FMT_J:        illegal = (imm_s < -1048576) || (imm_s > 1048574) || desc.imm[0];
      default:      illegal = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_q <= 1'b0;
    else        err_q <= accept & illegal & ~clear;
  end

  assign err = err_q;
`else
  assign illegal = 1'b0;
  assign err     = 1'b0;
`endif

  assign in_ready = ~full;
  assign accept   = in_valid & in_ready;
  assign push     = accept & ~illegal & ~clear;
  assign pop      = out_valid & out_ready & ~clear;

  rv_enc_fifo2 #(.WIDTH(32)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear),
    .push      (push),
    .push_data (word),
    .pop       (pop),
    .valid     (out_valid),
    .full      (full),
    .head      (out_instr)
  );

  // Address tracks the head word, so it only moves on output handshakes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     out_addr <= BASE_ADDR;
    else if (clear) out_addr <= BASE_ADDR;
    else if (pop)   out_addr <= out_addr + ADDR_W'(4);
  end

endmodule
